mult_share_arbiter: RTL

// Time-multiplexes one pipelined signed multiplier (registered operands, fixed latency, saturated product)

---
 rtl/mult_share_arbiter_if.sv | 28 ++
 rtl/mult_share_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mult_share_arbiter_if.sv
// Requester and multiplier bundle of the shared-multiplier arbiter.
// The arbiter connects through the slave modport; the requester/multiplier side uses master.
interface mult_share_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 14,
  parameter int unsigned BW   = 14,
  parameter int unsigned PW   = 14
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*AW-1:0]     req_a;
  logic [NREQ*BW-1:0]     req_b;
  logic signed [AW-1:0]   mult_a;
  logic signed [BW-1:0]   mult_b;
  logic signed [PW-1:0]   mult_p;
  logic [NREQ-1:0]        res_valid;
  logic signed [PW-1:0]   res_data;

  modport master (
    output req_valid, req_a, req_b, mult_p,
    input  req_ready, mult_a, mult_b, res_valid, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, mult_p,
    output req_ready, mult_a, mult_b, res_valid, res_data
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one pipelined multiplier among NREQ requesters; results routed back by tag.
// Optional grant counter enabled by defining MULT_SHARE_STATS_EN.
module mult_share_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 14,
  parameter int unsigned BW       = 14,
  parameter int unsigned PW       = 14,
  parameter int unsigned MULT_LAT = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 enable_i,
  mult_share_arbiter_if.slave  bus,
  output logic                 busy_o,
  input  logic                 clr_stats_i,
  output logic [31:0]          grant_cnt_o
);
  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IdxW-1:0]      ptr_q;
  logic [IdxW-1:0]      cand;
  logic [IdxW-1:0]      gnt_idx;
  logic                 gnt_any;
  logic [NREQ-1:0]      rdy;
  logic signed [AW-1:0] mult_a_q;
  logic signed [BW-1:0] mult_b_q;
  logic [MULT_LAT:0]    tag_v_q;
  logic [IdxW-1:0]      tag_idx_q [MULT_LAT+1];
  logic [NREQ-1:0]      res_valid_q;
  logic signed [PW-1:0] res_data_q;

  // Search starts just past the last winner so every requester is reached within NREQ grants.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = ptr_q;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_any && bus.req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (!(rstn_i && enable_i)) gnt_any = 1'b0;
    rdy = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      ptr_q       <= IdxW'(NREQ - 1);
      mult_a_q    <= '0;
      mult_b_q    <= '0;
      tag_v_q     <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
      for (int unsigned s = 0; s <= MULT_LAT; s++) tag_idx_q[s] <= '0;
    end else begin
      if (gnt_any) begin
        ptr_q    <= gnt_idx;
        mult_a_q <= bus.req_a[int'(gnt_idx)*AW +: AW];
        mult_b_q <= bus.req_b[int'(gnt_idx)*BW +: BW];
      end
      // Tag stage MULT_LAT lines up with the product of the operands loaded on that grant.
      tag_v_q      <= {tag_v_q[MULT_LAT-1:0], gnt_any};
      tag_idx_q[0] <= gnt_idx;
      for (int unsigned s = 1; s <= MULT_LAT; s++) tag_idx_q[s] <= tag_idx_q[s-1];
      res_valid_q <= '0;
      if (tag_v_q[MULT_LAT]) begin
        res_valid_q <= NREQ'(1) << tag_idx_q[MULT_LAT];
        res_data_q  <= bus.mult_p;
      end
    end
  end

  assign bus.req_ready = rdy;
  assign bus.mult_a    = mult_a_q;
  assign bus.mult_b    = mult_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign busy_o        = (|tag_v_q) | (|res_valid_q);

`ifdef MULT_SHARE_STATS_EN
  logic [31:0] grant_cnt_q;

  // Clear has priority over a grant in the same cycle; counter sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      grant_cnt_q <= '0;
    end else if (clr_stats_i) begin
      grant_cnt_q <= '0;
    end else if (gnt_any && (grant_cnt_q != 32'hFFFF_FFFF)) begin
      grant_cnt_q <= grant_cnt_q + 32'd1;
    end
  end

  assign grant_cnt_o = grant_cnt_q;
`else
  logic unused_clr_stats;

  assign unused_clr_stats = clr_stats_i;
  assign grant_cnt_o      = '0;
`endif
endmodule
